// File: rtl/rat_loader_pkg.sv
// rtl/rat_loader_pkg.sv - shared constants for the RAT program loader
// Holds the loader state codes, the default frame marker and the frame
// byte-layout constants used by prog_loader.
package rat_loader_pkg;

  // Loader states (plain constants so the encoding is fixed and visible)
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_CNT_LO = 4'd1;
  localparam logic [3:0] ST_CNT_HI = 4'd2;
  localparam logic [3:0] ST_B0     = 4'd3;
  localparam logic [3:0] ST_B1     = 4'd4;
  localparam logic [3:0] ST_B2     = 4'd5;
  localparam logic [3:0] ST_WRITE  = 4'd6;
  localparam logic [3:0] ST_CHK    = 4'd7;
  localparam logic [3:0] ST_DONE   = 4'd8;
  localparam logic [3:0] ST_ERR    = 4'd9;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Frame layout: SYNC, CNT_LO, CNT_HI, then WORD_BYTES bytes per word, then CHK
  localparam int unsigned CNT_W        = 11;  // {CNT_HI[2:0], CNT_LO}
  localparam int unsigned CNT_HI_BITS  = 3;
  localparam int unsigned WORD_BYTES   = 3;   // B0 = [7:0], B1 = [15:8], B2 = [17:16]
  localparam int unsigned B2_DATA_BITS = 2;

  // States in which a byte may be taken from the stream
  function automatic logic takes_byte(input logic [3:0] s);
    return (s == ST_IDLE) || (s == ST_CNT_LO) || (s == ST_CNT_HI) ||
           (s == ST_B0) || (s == ST_B1) || (s == ST_B2) || (s == ST_CHK);
  endfunction

  // States in which the inter-byte idle timer runs
  function automatic logic is_timed(input logic [3:0] s);
    return takes_byte(s) && (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream loader that writes RAT program memory
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   RX_DATA, RX_VALID   incoming byte stream
//   RX_READY            byte accepted this cycle when RX_VALID is also high
//   PROG_WE/ADDR/DATA   program memory write port (one pulse per word)
//   CPU_HOLD            keeps the CPU in reset while a frame is in progress
//   DONE, ERR           sticky result of the last frame
module prog_loader
  import rat_loader_pkg::*;
#(
  parameter int         ADDR_W      = 10,
  parameter int         DATA_W      = 18,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              PROG_WE,
  output logic [ADDR_W-1:0] PROG_ADDR,
  output logic [DATA_W-1:0] PROG_DATA,
  output logic              CPU_HOLD,
  output logic              DONE,
  output logic              ERR
);

  localparam int            TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W:0]  MAX_N   = (CNT_W + 1)'(2 ** ADDR_W);

  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic [7:0]        r_cnt_lo;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_b0;
  logic [7:0]        r_b1;
  logic [7:0]        r_xor;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [TO_W-1:0]   r_idle;
  logic              r_hold;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_timed;
  logic              w_timeout;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_cnt_bad;
  logic              w_b2_bad;
  logic              w_last;

  assign RX_READY  = takes_byte(r_state);
  assign w_accept  = RX_VALID && RX_READY;
  assign w_timed   = is_timed(r_state);
  // An accepted byte always wins over an expiring timer
  assign w_timeout = w_timed && !w_accept && (r_idle == TO_LAST);

  assign w_cnt     = {RX_DATA[CNT_HI_BITS-1:0], r_cnt_lo};
  assign w_cnt_bad = (RX_DATA[7:CNT_HI_BITS] != '0) || (w_cnt == '0) ||
                     ({1'b0, w_cnt} > MAX_N);
  assign w_b2_bad  = (RX_DATA[7:B2_DATA_BITS] != '0);
  // Index is compared one ahead so a full 2**ADDR_W frame never needs a wider index
  assign w_last    = ((CNT_W'(r_idx) + CNT_W'(1)) == r_cnt);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && (RX_DATA == SYNC_BYTE)) w_next = ST_CNT_LO;
      ST_CNT_LO: if (w_accept) w_next = ST_CNT_HI;
      ST_CNT_HI: if (w_accept) w_next = w_cnt_bad ? ST_ERR : ST_B0;
      ST_B0:     if (w_accept) w_next = ST_B1;
      ST_B1:     if (w_accept) w_next = ST_B2;
      ST_B2:     if (w_accept) w_next = w_b2_bad ? ST_ERR : ST_WRITE;
      ST_WRITE:  w_next = w_last ? ST_CHK : ST_B0;
      ST_CHK:    if (w_accept) w_next = (RX_DATA == r_xor) ? ST_DONE : ST_ERR;
      ST_DONE:   w_next = ST_IDLE;
      ST_ERR:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (w_timeout) w_next = ST_ERR;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_cnt_lo <= '0;
      r_cnt    <= '0;
      r_b0     <= '0;
      r_b1     <= '0;
      r_xor    <= '0;
      r_idx    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_idle   <= '0;
      r_hold   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;

      if (!w_timed || w_accept || w_timeout) r_idle <= '0;
      else                                   r_idle <= r_idle + 1'b1;

      if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            if (RX_DATA == SYNC_BYTE) begin
              r_done <= 1'b0;
              r_err  <= 1'b0;
              r_hold <= 1'b1;
            end
          end
          ST_CNT_LO: r_cnt_lo <= RX_DATA;
          ST_CNT_HI: begin
            r_cnt <= w_cnt;
            r_idx <= '0;
            r_xor <= '0;
          end
          ST_B0: begin
            r_b0  <= RX_DATA;
            r_xor <= r_xor ^ RX_DATA;
          end
          ST_B1: begin
            r_b1  <= RX_DATA;
            r_xor <= r_xor ^ RX_DATA;
          end
          ST_B2: begin
            r_xor <= r_xor ^ RX_DATA;
            // Address/data are loaded here so they are stable for the whole WRITE cycle
            if (!w_b2_bad) begin
              r_addr <= r_idx;
              r_data <= DATA_W'({RX_DATA[B2_DATA_BITS-1:0], r_b1, r_b0});
            end
          end
          default: ;
        endcase
      end

      if (r_state == ST_WRITE) r_idx <= r_idx + 1'b1;

      // Result flags change on entry to the terminal states; CPU_HOLD only
      // drops on success, so a failed frame keeps the CPU parked
      if (w_next == ST_DONE) begin
        r_done <= 1'b1;
        r_hold <= 1'b0;
      end
      if (w_next == ST_ERR) r_err <= 1'b1;
    end
  end

  assign PROG_WE   = (r_state == ST_WRITE);
  assign PROG_ADDR = r_addr;
  assign PROG_DATA = r_data;
  assign CPU_HOLD  = r_hold;
  assign DONE      = r_done;
  assign ERR       = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 18;
  localparam int TO     = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [7:0]        RX_DATA = 8'h00;
  logic              RX_VALID = 1'b0;
  logic              RX_READY;
  logic              PROG_WE;
  logic [ADDR_W-1:0] PROG_ADDR;
  logic [DATA_W-1:0] PROG_DATA;
  logic              CPU_HOLD;
  logic              DONE;
  logic              ERR;

  always #5 CLK = ~CLK;

  prog_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_READY(RX_READY), .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR),
    .PROG_DATA(PROG_DATA), .CPU_HOLD(CPU_HOLD), .DONE(DONE), .ERR(ERR)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Companion RAM model and write log, fed only by the DUT write port
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int                wr_a[$];
  logic [DATA_W-1:0] wr_d[$];
  int                we_ready_bad = 0;

  always @(negedge CLK) begin
    if (PROG_WE === 1'b1) begin
      wr_a.push_back(int'(PROG_ADDR));
      wr_d.push_back(PROG_DATA);
      mem[PROG_ADDR] = PROG_DATA;
    end
    if (PROG_WE && RX_READY) we_ready_bad++;
  end

  // Reference model: parses a byte list as a frame and lists the expected writes.
  // Returns 1 for a good frame, 2 for a rejected frame, 0 if the list ends early.
  int                exp_a[$];
  logic [DATA_W-1:0] exp_d[$];

  function automatic int model_frame(input logic [7:0] fb[$]);
    int         p = 0;
    int         n;
    logic [7:0] x = 8'h00;
    logic [7:0] b0, b1, b2;
    exp_a.delete();
    exp_d.delete();
    while (p < fb.size() && fb[p] != 8'hA5) p++;
    p++;
    if (p + 2 > fb.size()) return 0;
    n = int'(fb[p]) + 256 * int'(fb[p+1] & 8'h07);
    if (fb[p+1] > 8'h07 || n == 0 || n > (1 << ADDR_W)) return 2;
    p += 2;
    for (int i = 0; i < n; i++) begin
      if (p + 3 > fb.size()) return 0;
      b0 = fb[p]; b1 = fb[p+1]; b2 = fb[p+2];
      if (b2 > 8'h03) return 2;
      exp_a.push_back(i);
      exp_d.push_back({b2[1:0], b1, b0});
      x = x ^ b0 ^ b1 ^ b2;
      p += 3;
    end
    if (p >= fb.size()) return 0;
    return (fb[p] == x) ? 1 : 2;
  endfunction

  function automatic int cmp_writes();
    int m = (wr_a.size() != exp_a.size()) ? 1 : 0;
    for (int i = 0; i < wr_a.size() && i < exp_a.size(); i++)
      if (wr_a[i] != exp_a[i] || wr_d[i] !== exp_d[i]) m++;
    return m;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int   g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    int   waitc = 0;
    logic acc = 1'b0;
    repeat (g) begin
      RX_VALID = 1'b0;
      RX_DATA  = 8'($urandom);
      @(posedge CLK); #1;
    end
    RX_DATA  = b;
    RX_VALID = 1'b1;
    do begin
      @(negedge CLK);
      acc = RX_READY;
      @(posedge CLK); #1;
      waitc++;
    end while (!acc && waitc < 40);
    RX_VALID = 1'b0;
    if (!acc) check("accept_bound", 32'd0, 32'd1);
  endtask

  // Sends a byte list; hold_ok reports whether CPU_HOLD stayed high from SYNC
  // up to (not including) the final byte.
  task automatic send_frame(input logic [7:0] fb[$], input int max_gap, output logic hold_ok);
    logic seen = 1'b0;
    hold_ok = 1'b1;
    wr_a.delete();
    wr_d.delete();
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i], max_gap);
      if (fb[i] == 8'hA5) seen = 1'b1;
      if (seen && i != fb.size() - 1 && CPU_HOLD !== 1'b1) hold_ok = 1'b0;
    end
    repeat (3) begin @(posedge CLK); #1; end
  endtask

  typedef struct {
    logic [7:0] b [0:11];
    int         len;
    logic       e_done;
    logic       e_err;
    logic       e_hold;
    int         e_nw;
    int         max_gap;
  } vec_t;

  function automatic vec_t mkv(input logic [95:0] bytes_v, input int len, input logic d,
                               input logic e, input logic h, input int nw, input int gap);
    vec_t v;
    for (int i = 0; i < 12; i++) v.b[i] = (i < len) ? bytes_v[8*(len-1-i) +: 8] : 8'h00;
    v.len = len; v.e_done = d; v.e_err = e; v.e_hold = h; v.e_nw = nw; v.max_gap = gap;
    return v;
  endfunction

  vec_t       vt[9];
  logic [7:0] fb[$];
  logic       hold_ok;
  int         st;

  initial begin
    vt[0] = mkv(96'hA5_02_00_11_22_01_33_44_02_47, 10, 1, 0, 0, 2, 0);
    vt[1] = mkv(96'hA5_02_00_11_22_01_33_44_02_00, 10, 0, 1, 1, 2, 0);
    vt[2] = mkv(96'hA5_02_00_11_22_01_33_44_02_47, 10, 1, 0, 0, 2, 0);
    vt[3] = mkv(96'hA5_00_00,                       3, 0, 1, 1, 0, 0);
    vt[4] = mkv(96'hA5_01_04,                       3, 0, 1, 1, 0, 0);
    vt[5] = mkv(96'hA5_01_00_11_22_04,              6, 0, 1, 1, 0, 0);
    vt[6] = mkv(96'h00_FF_A5_01_00_FF_FF_03_03,     9, 1, 0, 0, 1, 3);
    vt[7] = mkv(96'hA5_01_08,                       3, 0, 1, 1, 0, 0);
    vt[8] = mkv(96'hA5_01_00_A5_A5_00_00,           7, 1, 0, 0, 1, 2);

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rst_ready", RX_READY, 1);
    check("rst_we", PROG_WE, 0);
    check("rst_addr", PROG_ADDR, 0);
    check("rst_data", PROG_DATA, 0);
    check("rst_hold", CPU_HOLD, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);

    // Table-driven frames
    for (int v = 0; v < 9; v++) begin
      fb.delete();
      for (int i = 0; i < vt[v].len; i++) fb.push_back(vt[v].b[i]);
      st = model_frame(fb);
      send_frame(fb, vt[v].max_gap, hold_ok);
      check($sformatf("v%0d_done", v), DONE, vt[v].e_done);
      check($sformatf("v%0d_err", v), ERR, vt[v].e_err);
      check($sformatf("v%0d_hold", v), CPU_HOLD, vt[v].e_hold);
      check($sformatf("v%0d_nwrites", v), wr_a.size(), vt[v].e_nw);
      check($sformatf("v%0d_writes", v), cmp_writes(), 0);
      check($sformatf("v%0d_hold_during", v), hold_ok, 1);
    end

    // Random frames with junk before SYNC and random RX_VALID gaps
    for (int r = 0; r < 8; r++) begin
      int         n;
      logic [7:0] x, b0, b1, b2, jb;
      logic       bad;
      fb.delete();
      repeat ($urandom_range(2, 0)) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h5A;
        fb.push_back(jb);
      end
      n = $urandom_range(6, 1);
      fb.push_back(8'hA5); fb.push_back(8'(n)); fb.push_back(8'h00);
      x = 8'h00; bad = 1'b0;
      for (int i = 0; i < n; i++) begin
        b0 = 8'($urandom); b1 = 8'($urandom);
        b2 = ($urandom_range(9, 0) == 0) ? 8'h04 : 8'($urandom_range(3, 0));
        fb.push_back(b0); fb.push_back(b1); fb.push_back(b2);
        x = x ^ b0 ^ b1 ^ b2;
        if (b2 > 8'h03) begin bad = 1'b1; break; end
      end
      if (!bad) fb.push_back(($urandom_range(3, 0) == 0) ? (x ^ 8'h01) : x);
      st = model_frame(fb);
      send_frame(fb, 4, hold_ok);
      check($sformatf("r%0d_done", r), DONE, (st == 1));
      check($sformatf("r%0d_err", r), ERR, (st == 2));
      check($sformatf("r%0d_hold", r), CPU_HOLD, (st != 1));
      check($sformatf("r%0d_writes", r), cmp_writes(), 0);
    end

    // Stall inside a word: ERR after TO idle cycles
    begin
      int k = 0;
      wr_a.delete(); wr_d.delete();
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h11, 0);
      do begin @(posedge CLK); #1; k++; end while (ERR !== 1'b1 && k < 40);
      check("timeout_cycles", k, TO);
      check("timeout_err", ERR, 1);
      check("timeout_hold", CPU_HOLD, 1);
      repeat (2) begin @(posedge CLK); #1; end
      check("timeout_nwrites", wr_a.size(), 0);
    end

    // Reset mid-frame
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h01, 0); send_byte(8'h33, 0);
    check("prerst_data", PROG_DATA, 32'h12211);
    check("prerst_hold", CPU_HOLD, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("midrst_ready", RX_READY, 1);
    check("midrst_we", PROG_WE, 0);
    check("midrst_addr", PROG_ADDR, 0);
    check("midrst_data", PROG_DATA, 0);
    check("midrst_hold", CPU_HOLD, 0);
    check("midrst_done", DONE, 0);
    check("midrst_err", ERR, 0);
    RST = 1'b0;

    // Full-depth frame, data = address
    begin
      logic [7:0] x = 8'h00;
      int         bad_rd = 0;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '1;
      fb.delete();
      fb.push_back(8'hA5); fb.push_back(8'h00); fb.push_back(8'h04);
      for (int i = 0; i < (1 << ADDR_W); i++) begin
        fb.push_back(8'(i)); fb.push_back(8'(i >> 8)); fb.push_back(8'h00);
        x = x ^ 8'(i) ^ 8'(i >> 8);
      end
      fb.push_back(x);
      send_frame(fb, 0, hold_ok);
      check("full_nwrites", wr_a.size(), 1 << ADDR_W);
      if (wr_a.size() > 0) begin
        check("full_last_addr", wr_a[wr_a.size()-1], 32'h3FF);
        check("full_last_data", wr_d[wr_d.size()-1], 32'h003FF);
      end else begin
        check("full_last_write", 32'd0, 32'd1);
      end
      check("full_done", DONE, 1);
      check("full_err", ERR, 0);
      check("full_hold", CPU_HOLD, 0);
      for (int i = 0; i < (1 << ADDR_W); i++)
        if (mem[i] !== DATA_W'(i)) bad_rd++;
      check("full_readback", bad_rd, 0);
    end

    check("we_while_ready", we_ready_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
